// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// default operand width.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor
  import serial_subtractor_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow generated/propagated through this bit
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, diff = a - b - bin, LSB first.
// Optional macro SERIAL_SUB_OVF_EN adds the registered signed-overflow
// output ovf.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepted edge
// SHIFT | one bit processed per clock, WIDTH clocks total
// DONE  | done pulse cycle; results valid and held
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             d_bit;
  logic             br_next;

  full_subtractor u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (br_next)
  );

  // Result shift register input: new bit enters at the MSB end
  always_comb begin
    res_next            = res >> 1;
    res_next[WIDTH-1]   = d_bit;
  end

  // Control FSM, datapath shift registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      res   <= '0;
      cnt   <= '0;
      br    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= bin;
            res   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          br   <= br_next;
          res  <= res_next;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            diff  <= res_next;
            bout  <= br_next;
`ifdef SERIAL_SUB_OVF_EN
            // br is the borrow into the MSB on this final bit
            ovf   <= br ^ br_next;
`endif
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor computing diff = a − b − bin, LSB first, one bit per clock through a single full-subtractor cell. It is the subtract-direction counterpart of the arithmetic datapath's adders. It serves area-constrained datapaths where a WIDTH-bit ripple subtractor is too large. A start/busy/done handshake gives a fixed, data-independent latency.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 1..32.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- bin  input  1  borrow-in; captured on the accepted start edge.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle completion pulse.
- diff  output  WIDTH  result; registered.
- bout  output  1  borrow-out; registered.
- ovf  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- **IDLE**
  - start=1: load a and b into shift registers, load the borrow flop with bin, clear the bit counter, go to SHIFT.
  - start=0: stay in IDLE.
- **SHIFT**, on each edge:
  - d = a0 ^ b0 ^ br.
  - br' = (~a0 & b0) | (~(a0 ^ b0) & br).
  - Shift d into the result shift register from the MSB end; shift a and b right by one.
  - Increment the counter. The edge that processes bit WIDTH−1 loads diff and bout, sets done, and goes to DONE.
- **DONE**: next edge clears done and goes to IDLE.
- start is ignored in SHIFT and DONE. Operands are never re-sampled mid-operation.
- diff and bout hold the last completed result until the next completion. They do not change during SHIFT.
- Arithmetic is modulo 2^WIDTH. bout=1 exactly when a < b + bin, unsigned.
- Reset in any state, including mid-SHIFT, aborts the operation. Next cycle: IDLE, with all outputs and internal registers zero.
- Reset values: busy=0, done=0, diff=0, bout=0, ovf=0.

## Timing
- The accepted start edge is E0. Bit i is processed on edge E(i+1).
- done=1, with diff and bout valid, in the cycle following edge E(WIDTH).
- busy=1 from after E0 until E(WIDTH); busy=0 while done=1.
- Earliest next accepted start is edge E(WIDTH+2), which is the IDLE cycle. Throughput is one operation per WIDTH+2 cycles.
- WIDTH=1: one SHIFT cycle; done follows E1.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - The ovf port exists. It is registered together with diff.
  - ovf = (borrow into MSB) ^ bout, i.e. two's-complement overflow of a − b − bin.
  - ovf holds and resets like diff.
- SERIAL_SUB_OVF_EN undefined: the ovf port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package/include holds:
  - the state encoding constants IDLE=2'd0, SHIFT=2'd1, DONE=2'd2;
  - the default WIDTH constant.
- One sub-module, full_subtractor: combinational 1-bit cell. Ports: a, b, bin, d, bout.
- The top level holds the FSM, the counter of $clog2(WIDTH+1) bits, the shift registers and the output registers.

## Test plan
- Reset asserted for 2 cycles, then released: busy=0, done=0, diff=0, bout=0, ovf=0 (ovf when enabled).
- a=200, b=55, bin=0, start at E0: done after E8; diff=145, bout=0.
- a=5, b=10, bin=0: diff=251, bout=1. Then a=0, b=0, bin=1: diff=255, bout=1.
- start held high with new operands for the whole SHIFT period: the first result is unaffected. The second operation is accepted only in IDLE, at E10.
- rst pulsed after E4 of an operation: next cycle IDLE, diff=0, no done pulse. A fresh start then completes normally.
- With SERIAL_SUB_OVF_EN:
  - a=8'h80, b=8'h01: diff=8'h7F, ovf=1, bout=0.
  - a=8'h10, b=8'h01: diff=8'h0F, ovf=0.
